// File: rtl/i2c_reg_bank_ctrl_if.sv
// i2c_reg_bank_ctrl_if
//   Bundles the I2C slave byte-level handshake, the local host port and the
//   status outputs of i2c_reg_bank_ctrl.
//   slave  : view of the register bank controller (DUT side)
//   master : view of whoever drives the I2C byte engine and the host port
// Signals:
//   i2c_start/i2c_rnw/i2c_stop  transaction framing pulses from the I2C slave
//   rx_valid/rx_data            byte received from the I2C master
//   tx_req -> tx_valid/tx_data  next byte to transmit, answered 1 cycle later
//   host_*                      single-cycle host register access, gnt is comb
//   ptr, irq_wr, irq_addr       register pointer and write notification
interface i2c_reg_bank_ctrl_if #(
    parameter int ADDR_W = 4
);
    logic              i2c_start;
    logic              i2c_rnw;
    logic              i2c_stop;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              tx_req;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              host_req;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [7:0]        host_wdata;
    logic              host_gnt;
    logic [7:0]        host_rdata;
    logic [7:0]        ptr;
    logic              irq_wr;
    logic [ADDR_W-1:0] irq_addr;

    modport slave (
        input  i2c_start, i2c_rnw, i2c_stop, rx_valid, rx_data, tx_req,
        input  host_req, host_we, host_addr, host_wdata,
        output tx_data, tx_valid, host_gnt, host_rdata, ptr, irq_wr, irq_addr
    );

    modport master (
        output i2c_start, i2c_rnw, i2c_stop, rx_valid, rx_data, tx_req,
        output host_req, host_we, host_addr, host_wdata,
        input  tx_data, tx_valid, host_gnt, host_rdata, ptr, irq_wr, irq_addr
    );
endinterface

// File: rtl/i2c_reg_bank_ctrl.sv
// i2c_reg_bank_ctrl
//   Maps I2C slave byte traffic onto a NUM_REGS x 8 register bank. The first
//   byte of a master write loads the register pointer, following bytes write
//   the bank with auto-increment; master reads stream the bank from the
//   pointer. A local host port shares the single-ported bank and only gets
//   access in cycles the I2C side does not use (the slave cannot stretch).
// Ports:
//   clock  system clock
//   reset  asynchronous active-low reset
//   bus    i2c_reg_bank_ctrl_if.slave (I2C byte handshake, host port, status)
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | no transaction open, received bytes ignored
// GET_PTR | write transaction opened, next byte is the register pointer
// WR_DATA | pointer loaded, received bytes write the bank
// RD_DATA | read transaction, tx requests stream the bank
module i2c_reg_bank_ctrl #(
    parameter int                  NUM_REGS  = 16,
    parameter int                  ADDR_W    = $clog2(NUM_REGS),
    parameter logic [7:0]          RESET_VAL = 8'h00,
    parameter logic [NUM_REGS-1:0] RO_MASK   = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    i2c_reg_bank_ctrl_if.slave    bus
);

    typedef enum logic [1:0] {IDLE, GET_PTR, WR_DATA, RD_DATA} state_t;

    localparam logic [7:0] LAST_PTR = 8'(NUM_REGS - 1);

    state_t            state_q;
    logic [7:0]        ptr_q;
    logic [7:0]        regs_q [NUM_REGS];
    logic [7:0]        tx_data_q;
    logic              tx_valid_q;
    logic [7:0]        host_rdata_q;
    logic              irq_wr_q;
    logic [ADDR_W-1:0] irq_addr_q;

    logic              ptr_in_range;
    logic [ADDR_W-1:0] ptr_idx;
    logic [7:0]        ptr_inc;
    logic              wr_access;
    logic              rd_access;
    logic              i2c_access;
    logic              host_gnt;
    logic              host_in_range;

    assign ptr_in_range  = 32'(ptr_q) < NUM_REGS;
    assign ptr_idx       = ptr_q[ADDR_W-1:0];
    // Out-of-range pointers stick so a runaway master cannot wrap into the bank.
    assign ptr_inc       = !ptr_in_range        ? ptr_q :
                           (ptr_q == LAST_PTR)  ? 8'h00 : ptr_q + 8'd1;

    assign wr_access     = (state_q == WR_DATA) && bus.rx_valid;
    assign rd_access     = (state_q == RD_DATA) && bus.tx_req;
    assign i2c_access    = wr_access || rd_access;
    assign host_gnt      = bus.host_req && !i2c_access;
    assign host_in_range = 32'(bus.host_addr) < NUM_REGS;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            ptr_q        <= 8'h00;
            tx_data_q    <= 8'h00;
            tx_valid_q   <= 1'b0;
            host_rdata_q <= 8'h00;
            irq_wr_q     <= 1'b0;
            irq_addr_q   <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= RESET_VAL;
            end
        end else begin
            tx_valid_q <= bus.tx_req;
            irq_wr_q   <= 1'b0;

            // Every tx request is answered; only a live read returns bank data.
            if (bus.tx_req) begin
                tx_data_q <= (rd_access && ptr_in_range) ? regs_q[ptr_idx] : 8'hFF;
            end

            case (state_q)
                GET_PTR: begin
                    if (bus.rx_valid) begin
                        ptr_q   <= bus.rx_data;
                        state_q <= WR_DATA;
                    end
                end
                WR_DATA: begin
                    if (bus.rx_valid) begin
                        if (ptr_in_range && !RO_MASK[ptr_idx]) begin
                            regs_q[ptr_idx] <= bus.rx_data;
                            irq_wr_q        <= 1'b1;
                            irq_addr_q      <= ptr_idx;
                        end
                        ptr_q <= ptr_inc;
                    end
                end
                RD_DATA: begin
                    if (bus.tx_req) begin
                        ptr_q <= ptr_inc;
                    end
                end
                default: ;
            endcase

            // Never coincides with an I2C bank access, so no write collision.
            if (host_gnt) begin
                if (bus.host_we) begin
                    if (host_in_range) begin
                        regs_q[bus.host_addr] <= bus.host_wdata;
                    end
                end else begin
                    host_rdata_q <= host_in_range ? regs_q[bus.host_addr] : 8'hFF;
                end
            end

            // Framing overrides the byte-driven transition; start beats stop.
            if (bus.i2c_start) begin
                state_q <= bus.i2c_rnw ? RD_DATA : GET_PTR;
            end else if (bus.i2c_stop) begin
                state_q <= IDLE;
            end
        end
    end

    assign bus.tx_data    = tx_data_q;
    assign bus.tx_valid   = tx_valid_q;
    assign bus.host_gnt   = host_gnt;
    assign bus.host_rdata = host_rdata_q;
    assign bus.ptr        = ptr_q;
    assign bus.irq_wr     = irq_wr_q;
    assign bus.irq_addr   = irq_addr_q;

endmodule

// File: tb/tb_i2c_reg_bank_ctrl.sv
module tb_i2c_reg_bank_ctrl;
    localparam int          NR = 16;
    localparam int          AW = 4;
    localparam logic [15:0] RO = 16'h0004;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt++;

    i2c_reg_bank_ctrl_if #(.ADDR_W(AW)) bus ();

    i2c_reg_bank_ctrl #(
        .NUM_REGS (NR),
        .RESET_VAL(8'h00),
        .RO_MASK  (RO)
    ) dut (
        .clock(clk),
        .reset(rst_n),
        .bus  (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: bank contents, pointer and what the next byte means.
    typedef enum int {PH_NONE, PH_PTR, PH_WRITE, PH_READ} phase_t;
    logic [7:0] m_regs [NR];
    int         m_ptr;
    phase_t     m_phase;

    typedef struct {
        int         cyc;
        logic [7:0] data;
    } exp_t;
    exp_t tx_q[$];
    exp_t rd_q[$];
    int   irq_q[$];

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < NR; i++) m_regs[i] = 8'h00;
        m_ptr   = 0;
        m_phase = PH_NONE;
        tx_q.delete();
        rd_q.delete();
        irq_q.delete();
    endfunction

    function automatic int m_advance(int p);
        if (p >= NR) return p;
        return (p + 1) % NR;
    endfunction

    function automatic void m_rx(logic [7:0] d);
        if (m_phase == PH_PTR) begin
            m_ptr   = d;
            m_phase = PH_WRITE;
        end else if (m_phase == PH_WRITE) begin
            if (m_ptr < NR && !RO[m_ptr]) begin
                m_regs[m_ptr] = d;
                irq_q.push_back(m_ptr);
            end
            m_ptr = m_advance(m_ptr);
        end
    endfunction

    function automatic void m_tx(int cyc);
        exp_t e;
        e.cyc  = cyc;
        e.data = (m_phase == PH_READ && m_ptr < NR) ? m_regs[m_ptr] : 8'hFF;
        tx_q.push_back(e);
        if (m_phase == PH_READ) m_ptr = m_advance(m_ptr);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.i2c_start  = 1'b0;
        bus.i2c_rnw    = 1'b0;
        bus.i2c_stop   = 1'b0;
        bus.rx_valid   = 1'b0;
        bus.rx_data    = 8'h00;
        bus.tx_req     = 1'b0;
        bus.host_req   = 1'b0;
        bus.host_we    = 1'b0;
        bus.host_addr  = '0;
        bus.host_wdata = 8'h00;
    endtask

    task automatic do_start(input logic rnw);
        bus.i2c_start = 1'b1;
        bus.i2c_rnw   = rnw;
        m_phase       = rnw ? PH_READ : PH_PTR;
        step();
        clear_inputs();
    endtask

    task automatic do_stop();
        bus.i2c_stop = 1'b1;
        m_phase      = PH_NONE;
        step();
        clear_inputs();
    endtask

    task automatic do_rx(input logic [7:0] d);
        bus.rx_valid = 1'b1;
        bus.rx_data  = d;
        m_rx(d);
        step();
        clear_inputs();
    endtask

    task automatic do_tx();
        bus.tx_req = 1'b1;
        m_tx(cyc_cnt + 1);
        step();
        clear_inputs();
    endtask

    // exp < 0: expected read data comes from the model, else the given value.
    task automatic host(input logic we, input int addr, input logic [7:0] wdata, input int exp);
        exp_t e;
        bit   done = 0;
        bus.host_req   = 1'b1;
        bus.host_we    = we;
        bus.host_addr  = AW'(addr);
        bus.host_wdata = wdata;
        for (int n = 0; n < 20 && !done; n++) begin
            #3;
            if (bus.host_gnt) begin
                if (we) begin
                    if (addr < NR) m_regs[addr] = wdata;
                end else begin
                    e.cyc  = cyc_cnt + 1;
                    e.data = (exp >= 0) ? 8'(exp) : ((addr < NR) ? m_regs[addr] : 8'hFF);
                    rd_q.push_back(e);
                end
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) chk("host_gnt_timeout", 32'd0, 32'd1);
        clear_inputs();
    endtask

    task automatic drain();
        repeat (3) step();
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a response.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (bus.tx_valid) begin
                if (tx_q.size() == 0) begin
                    chk("tx_valid_spurious", 32'(bus.tx_valid), 32'd0);
                end else begin
                    e = tx_q.pop_front();
                    chk("tx_data", 32'(bus.tx_data), 32'(e.data));
                    chk("tx_latency_cycle", cyc_cnt, e.cyc);
                end
            end
            if (tx_q.size() != 0 && tx_q[0].cyc < cyc_cnt) begin
                e = tx_q.pop_front();
                chk("tx_valid_missing", 32'(bus.tx_valid), 32'd1);
            end
            if (bus.irq_wr) begin
                if (irq_q.size() == 0) begin
                    chk("irq_wr_spurious", 32'(bus.irq_wr), 32'd0);
                end else begin
                    chk("irq_addr", 32'(bus.irq_addr), 32'(irq_q.pop_front()));
                end
            end
            if (rd_q.size() != 0 && rd_q[0].cyc == cyc_cnt) begin
                e = rd_q.pop_front();
                chk("host_rdata", 32'(bus.host_rdata), 32'(e.data));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int op;
        clear_inputs();
        m_reset();
        repeat (2) step();
        chk("reset_ptr", 32'(bus.ptr), 32'h0);
        chk("reset_tx_data", 32'(bus.tx_data), 32'h0);
        chk("reset_tx_valid", 32'(bus.tx_valid), 32'h0);
        chk("reset_host_rdata", 32'(bus.host_rdata), 32'h0);
        chk("reset_irq_wr", 32'(bus.irq_wr), 32'h0);
        chk("reset_irq_addr", 32'(bus.irq_addr), 32'h0);
        rst_n = 1'b1;
        step();

        // Master write with pointer byte and auto-increment.
        do_start(1'b0);
        do_rx(8'h03);
        do_rx(8'hA5);
        do_rx(8'h5A);
        do_stop();
        chk("ptr_after_write", 32'(bus.ptr), 32'h5);
        host(1'b0, 3, 8'h00, 8'hA5);
        host(1'b0, 4, 8'h00, 8'h5A);

        // Read stream, then pointer write followed by repeated-start read.
        do_start(1'b1);
        do_tx();
        do_tx();
        do_tx();
        chk("ptr_after_read", 32'(bus.ptr), 32'h8);
        do_start(1'b0);
        do_rx(8'h03);
        do_start(1'b1);
        do_tx();
        do_stop();
        chk("ptr_after_rs_read", 32'(bus.ptr), 32'h4);

        // Wrap at the last register.
        do_start(1'b0);
        do_rx(8'h0F);
        do_rx(8'h11);
        do_rx(8'h22);
        do_stop();
        chk("ptr_after_wrap", 32'(bus.ptr), 32'h1);
        host(1'b0, 15, 8'h00, 8'h11);
        host(1'b0, 0, 8'h00, 8'h22);

        // Out-of-range pointer: writes dropped, reads 0xFF, pointer sticks.
        do_start(1'b0);
        do_rx(8'h20);
        do_rx(8'h77);
        chk("ptr_oor_write", 32'(bus.ptr), 32'h20);
        do_start(1'b1);
        do_tx();
        do_stop();
        chk("ptr_oor_read", 32'(bus.ptr), 32'h20);

        // tx request outside a read transaction.
        do_tx();
        chk("ptr_tx_idle", 32'(bus.ptr), 32'h20);

        // Read-only register from I2C, writable from host.
        do_start(1'b0);
        do_rx(8'h02);
        do_rx(8'hEE);
        do_stop();
        chk("ptr_after_ro", 32'(bus.ptr), 32'h3);
        host(1'b0, 2, 8'h00, 8'h00);
        host(1'b1, 2, 8'hEE, -1);
        host(1'b0, 2, 8'h00, 8'hEE);

        // Contention: I2C write and host write to reg6 in the same cycle.
        do_start(1'b0);
        do_rx(8'h06);
        bus.rx_valid   = 1'b1;
        bus.rx_data    = 8'h44;
        bus.host_req   = 1'b1;
        bus.host_we    = 1'b1;
        bus.host_addr  = 4'd6;
        bus.host_wdata = 8'h99;
        m_rx(8'h44);
        #3;
        chk("host_gnt_blocked", 32'(bus.host_gnt), 32'd0);
        step();
        bus.rx_valid = 1'b0;
        #3;
        chk("host_gnt_retry", 32'(bus.host_gnt), 32'd1);
        m_regs[6] = 8'h99;
        step();
        clear_inputs();
        do_stop();
        host(1'b0, 6, 8'h00, 8'h99);

        // Reset in the middle of a write transaction.
        do_start(1'b0);
        do_rx(8'h05);
        drain();
        #2;
        rst_n = 1'b0;
        m_reset();
        #2;
        chk("ptr_in_reset", 32'(bus.ptr), 32'h0);
        step();
        rst_n = 1'b1;
        step();
        do_rx(8'h12);
        chk("ptr_rx_after_reset", 32'(bus.ptr), 32'h0);
        for (int i = 0; i < NR; i++) host(1'b0, i, 8'h00, 8'h00);

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            op = $urandom_range(0, 9);
            case (op)
                0: do_start(1'($urandom_range(0, 1)));
                1: do_stop();
                2, 3, 4: begin
                    if (m_phase == PH_PTR) do_rx(8'($urandom_range(0, 19)));
                    else do_rx(8'($urandom));
                end
                5, 6: do_tx();
                default: host(1'($urandom_range(0, 1)), $urandom_range(0, NR - 1), 8'($urandom), -1);
            endcase
            chk("ptr_random", 32'(bus.ptr), 32'(m_ptr));
        end
        do_stop();
        for (int i = 0; i < NR; i++) host(1'b0, i, 8'h00, -1);

        drain();
        chk("tx_queue_empty", tx_q.size(), 0);
        chk("irq_queue_empty", irq_q.size(), 0);
        chk("rd_queue_empty", rd_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/i2c_reg_bank_ctrl.md
Name: i2c_reg_bank_ctrl

Overview:
- Sequences byte traffic between the I2C slave's byte-level interface and an internal NUM_REGS x 8 register bank.
- The first byte of a master write sets a register pointer. Subsequent bytes write the bank with auto-increment.
- Master reads stream bank contents from the pointer, also with auto-increment.
- Arbitrates the single-ported bank between the I2C side and a local host port. I2C always has priority because the slave does not clock-stretch.

Parameters:
- NUM_REGS, 16, number of 8-bit registers (2..256).
- ADDR_W, $clog2(NUM_REGS), host address width (derived).
- RESET_VAL, 8'h00, reset value of every register.
- RO_MASK, {NUM_REGS{1'b0}}, bit i = 1: register i is read-only from I2C (host may still write it).

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- i2c_start  in  1  one-cycle pulse: addressed transaction (or repeated start) began.
- i2c_rnw  in  1  direction, valid with i2c_start; 1 = master reads.
- i2c_stop  in  1  one-cycle pulse: STOP seen.
- rx_valid  in  1  one-cycle pulse: byte received from master.
- rx_data  in  8  received byte, valid with rx_valid.
- tx_req  in  1  one-cycle pulse: slave needs next byte to transmit.
- tx_data  out  8  byte to transmit, valid with tx_valid, held until next tx_valid.
- tx_valid  out  1  one-cycle pulse, exactly 1 cycle after tx_req.
- host_req  in  1  host access request, level.
- host_we  in  1  1 = write.
- host_addr  in  ADDR_W  host register index.
- host_wdata  in  8  host write data.
- host_gnt  out  1  combinational grant; access performed this cycle.
- host_rdata  out  8  read data, registered, valid 1 cycle after granted read.
- ptr  out  8  current register pointer (raw byte).
- irq_wr  out  1  one-cycle pulse: I2C master committed a register write.
- irq_addr  out  ADDR_W  index written, valid with irq_wr.

Behaviour:
- Reset (reset = 0, async):
  - state = IDLE, all registers = RESET_VAL, ptr = 0.
  - tx_data = 0, tx_valid = 0, host_rdata = 0, irq_wr = 0, irq_addr = 0.
  - Reset mid-transaction aborts it; rx_valid/tx_req are ignored until the next i2c_start.
- FSM states: IDLE, GET_PTR, WR_DATA, RD_DATA.
- i2c_start in any state: rnw = 0 -> GET_PTR; rnw = 1 -> RD_DATA. ptr is retained, so write-pointer then repeated-start read works.
- i2c_stop in any state -> IDLE. If i2c_start and i2c_stop arrive in the same cycle, start wins.
- GET_PTR:
  - rx_valid: ptr <= rx_data, -> WR_DATA. No bank access.
  - tx_req: answered per the tx rule below (0xFF).
- WR_DATA, on rx_valid:
  - If ptr < NUM_REGS and RO_MASK[ptr] = 0: reg[ptr] <= rx_data, irq_wr = 1 and irq_addr = ptr next cycle.
  - If ptr < NUM_REGS and RO_MASK[ptr] = 1: write dropped, no irq, ptr still increments.
  - If ptr >= NUM_REGS: write dropped, ptr not incremented.
  - Increment: ptr <= (ptr == NUM_REGS-1) ? 0 : ptr + 1.
- RD_DATA, on tx_req:
  - Next cycle tx_data = (ptr < NUM_REGS) ? reg[ptr] : 8'hFF, tx_valid = 1.
  - ptr increments with the same wrap/saturation rule as WR_DATA.
- tx_req outside RD_DATA: tx_valid still pulses after 1 cycle, tx_data = 8'hFF, ptr unchanged.
- rx_valid in IDLE or RD_DATA: ignored.
- Arbitration:
  - An I2C bank access occurs in a cycle with a qualifying rx_valid (WR_DATA) or tx_req (RD_DATA).
  - host_gnt = host_req & ~i2c_access. Ungranted host requests hold their inputs and retry.
  - Granted host write: reg[host_addr] <= host_wdata at that edge. RO_MASK is ignored; no irq.
  - Granted host read: host_rdata <= reg[host_addr] at that edge.
  - host_addr >= NUM_REGS: write dropped, read returns 8'hFF.
  - Read-after-write is ordered by cycle. A read in the cycle after a write to the same register returns the new value.
- No I2C stall path exists: every rx_valid/tx_req is serviced in its cycle.

Test Plan:
- Reset, then master write: start(rnw=0), rx 0x03, 0xA5, 0x5A, stop -> reg3 = 0xA5, reg4 = 0x5A, ptr = 5, irq_wr pulses with irq_addr 3 then 4.
- After the above, start(rnw=1), three tx_req -> tx_data 0x00 (reg5), 0x00, 0x00, ptr = 8. Then start(rnw=0), rx 0x03, repeated start(rnw=1), tx_req -> tx_data 0xA5, each tx_valid exactly 1 cycle after tx_req.
- Wrap: ptr 0x0F, write 0x11, 0x22 -> reg15 = 0x11, reg0 = 0x22, ptr = 1. Out-of-range: ptr 0x20, write 0x77 -> no register changes, no irq, ptr stays 0x20; read -> 0xFF.
- RO_MASK = 16'h0004: I2C write 0xEE to reg2 -> reg2 unchanged, no irq, ptr = 3. Host write 0xEE to reg2 -> reg2 = 0xEE.
- Contention: host_req write reg6 = 0x99 held in the same cycle as I2C rx_valid writing reg6 = 0x44 -> host_gnt = 0 that cycle, I2C write lands first; host granted next cycle, final reg6 = 0x99.
- Assert reset mid-WR_DATA after the pointer byte -> all registers = 0x00, ptr = 0, state IDLE. rx_valid 0x12 with no new start -> ignored.
